// File: rtl/frame_scheduler.sv
// Frame-synchronous scheduler for a cellular-automaton display.
// Commands (pan/zoom) are collected during a frame and applied together on the
// frame tick so the viewport never changes mid-frame. A small FSM requests one
// generation from the evolution engine every (speed+1) frames, or on a single
// step while paused.
//
// Ports:
//   clk, rst            pixel clock, asynchronous active-high reset
//   vsync               raw vsync from the timing block (polarity set by VSPP)
//   pan_*/zoom_*        one-cycle command pulses, applied at the next frame tick
//   pause_toggle, step  one-cycle pulses; step only honoured while paused
//   speed               frames per generation minus one
//   setting_status      manual edit mode; holds off generation requests
//   evo_done            one-cycle completion pulse from the evolution engine
//   shift_x, shift_y    viewport origin in cells
//   scroll              zoom shift
//   evo_start           one-cycle generation request
//   running, evo_busy   run state and engine-busy indication
//   overrun             sticky: a generation fell due while the engine was busy
//   gen_count           generations completed (wraps)
module frame_scheduler #(
  parameter int unsigned VSPP       = 0,
  parameter int unsigned HSIZE      = 800,
  parameter int unsigned VSIZE      = 600,
  parameter int unsigned P_PARAM_N  = 1024,
  parameter int unsigned P_PARAM_M  = 1024,
  parameter int unsigned MAX_SCROLL = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        pan_left,
  input  logic        pan_right,
  input  logic        pan_up,
  input  logic        pan_down,
  input  logic        zoom_in,
  input  logic        zoom_out,
  input  logic        pause_toggle,
  input  logic        step,
  input  logic [3:0]  speed,
  input  logic        setting_status,
  input  logic        evo_done,
  output logic [15:0] shift_x,
  output logic [15:0] shift_y,
  output logic [3:0]  scroll,
  output logic        evo_start,
  output logic        running,
  output logic        evo_busy,
  output logic        overrun,
  output logic [15:0] gen_count
);

  typedef enum logic [1:0] {StIdle, StArm, StBusy} state_e;

  state_e      state_q, state_d;
  logic        vs1_q, vs2_q;
  logic        act1, act2, frame_tick;
  logic [5:0]  pend_q, pend_d, cmd_in;
  logic [15:0] shift_x_q, shift_x_d, shift_y_q, shift_y_d;
  logic [3:0]  scroll_q, scroll_d;
  logic        running_q, running_d;
  logic        step_pend_q, step_pend_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic        overrun_q, overrun_d;
  logic [15:0] gen_count_q, gen_count_d;
  logic        gen_due;

  int unsigned sc_new, hvis, vvis, maxx, maxy, x_new, y_new;

  // Tick on the first active sample: vs1 already active, vs2 not yet.
  assign act1       = (VSPP != 0) ? vs1_q : ~vs1_q;
  assign act2       = (VSPP != 0) ? vs2_q : ~vs2_q;
  assign frame_tick = act1 & ~act2;

  // Bit order: {zoom_out, zoom_in, down, up, right, left}
  assign cmd_in = {zoom_out, zoom_in, pan_down, pan_up, pan_right, pan_left};

  // A pulse in the tick cycle itself seeds the next frame's pending set.
  assign pend_d = frame_tick ? cmd_in : (pend_q | cmd_in);

  // Viewport update: zoom first, then pan, then clamp against the new zoom.
  always_comb begin
    sc_new = 32'(scroll_q);
    if (pend_q[4] && !pend_q[5] && (sc_new < MAX_SCROLL)) begin
      sc_new = sc_new + 1;
    end else if (pend_q[5] && !pend_q[4] && (sc_new != 0)) begin
      sc_new = sc_new - 1;
    end
    hvis = HSIZE >> sc_new;
    vvis = VSIZE >> sc_new;
    maxx = (P_PARAM_N > hvis) ? (P_PARAM_N - hvis) : 0;
    maxy = (P_PARAM_M > vvis) ? (P_PARAM_M - vvis) : 0;

    x_new = 32'(shift_x_q);
    if (pend_q[1] && !pend_q[0]) begin
      x_new = x_new + 1;
    end else if (pend_q[0] && !pend_q[1] && (x_new != 0)) begin
      x_new = x_new - 1;
    end
    if (x_new > maxx) x_new = maxx;

    y_new = 32'(shift_y_q);
    if (pend_q[3] && !pend_q[2]) begin
      y_new = y_new + 1;
    end else if (pend_q[2] && !pend_q[3] && (y_new != 0)) begin
      y_new = y_new - 1;
    end
    if (y_new > maxy) y_new = maxy;

    shift_x_d = shift_x_q;
    shift_y_d = shift_y_q;
    scroll_d  = scroll_q;
    if (frame_tick) begin
      shift_x_d = x_new[15:0];
      shift_y_d = y_new[15:0];
      scroll_d  = sc_new[3:0];
    end
  end

  // Run control, frame divider and generation FSM.
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    gen_due     = 1'b0;
    running_d   = running_q ^ pause_toggle;
    step_pend_d = step_pend_q | (step & ~running_q);
    overrun_d   = overrun_q;
    gen_count_d = gen_count_q;

    if (frame_tick && running_q) begin
      if (fcnt_q == speed) begin
        fcnt_d  = 4'd0;
        gen_due = 1'b1;
      end else begin
        fcnt_d = fcnt_q + 4'd1;
      end
    end

    case (state_q)
      StIdle: begin
        if (frame_tick && (gen_due || step_pend_q) && !setting_status) begin
          state_d     = StArm;
          step_pend_d = step & ~running_q;
        end
      end
      StArm: begin
        state_d = StBusy;
        if (frame_tick && gen_due) overrun_d = 1'b1;
      end
      StBusy: begin
        // A due generation while busy is dropped, only flagged.
        if (frame_tick && gen_due) overrun_d = 1'b1;
        if (evo_done) begin
          state_d     = StIdle;
          gen_count_d = gen_count_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      vs1_q       <= 1'b0;
      vs2_q       <= 1'b0;
      pend_q      <= '0;
      shift_x_q   <= '0;
      shift_y_q   <= '0;
      scroll_q    <= '0;
      running_q   <= 1'b0;
      step_pend_q <= 1'b0;
      fcnt_q      <= '0;
      overrun_q   <= 1'b0;
      gen_count_q <= '0;
    end else begin
      state_q     <= state_d;
      vs1_q       <= vsync;
      vs2_q       <= vs1_q;
      pend_q      <= pend_d;
      shift_x_q   <= shift_x_d;
      shift_y_q   <= shift_y_d;
      scroll_q    <= scroll_d;
      running_q   <= running_d;
      step_pend_q <= step_pend_d;
      fcnt_q      <= fcnt_d;
      overrun_q   <= overrun_d;
      gen_count_q <= gen_count_d;
    end
  end

  assign shift_x   = shift_x_q;
  assign shift_y   = shift_y_q;
  assign scroll    = scroll_q;
  assign running   = running_q;
  assign overrun   = overrun_q;
  assign gen_count = gen_count_q;
  assign evo_start = (state_q == StArm);
  assign evo_busy  = (state_q != StIdle);

endmodule
